mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_pkg.sv | 8 +
 rtl/lane_merge.sv | 25 ++
 rtl/mem_access_unit.sv | 75 +++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: size and FSM state encodings shared by the memory access unit.
package mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RMW_WR = 1'b1;
endpackage

// File: rtl/lane_merge.sv
// lane_merge: little-endian lane insertion for stores and lane extraction with extension for loads.
module lane_merge
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] ext
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b      = word[8*off +: 8];
        h      = off[1] ? word[31:16] : word[15:0];
        merged = word;
        if (size == SZ_BYTE) merged[8*off +: 8] = wdata[7:0];
        else if (size == SZ_HALF) merged[16*off[1] +: 16] = wdata[15:0];
        ext = size == SZ_BYTE ? {{24{b[7] & ~unsigned_ld}}, b}
            : size == SZ_HALF ? {{16{h[15] & ~unsigned_ld}}, h}
            : word;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU load/store front end; sub-word stores run as a two-cycle read-modify-write.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    logic [0:0]           state_q, state_d;
    logic [31:0]          merge_q, merge_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic                 idle, rmw, legal, any_req, ld, st_word, st_sub;
    logic [31:0]          merged, ext;
    logic                 unused_addr;

    assign unused_addr = ^addr[31:ADDR_BITS+2];

    lane_merge u_lane_merge (
        .size        (size),
        .unsigned_ld (unsigned_ld),
        .off         (addr[1:0]),
        .word        (mem_rdata),
        .wdata       (wdata),
        .merged      (merged),
        .ext         (ext)
    );

    // Requests are only decoded in IDLE; during RMW_WR the CPU is holding them for us.
    always_comb begin
        idle      = rst_n && state_q == ST_IDLE;
        rmw       = rst_n && state_q == ST_RMW_WR;
        legal     = size == SZ_BYTE || (size == SZ_HALF && !addr[0]) || (size == SZ_WORD && addr[1:0] == 2'b00);
        any_req   = idle && (req_read || req_write);
        err       = any_req && (!legal || (req_read && req_write));
        ld        = any_req && !err && req_read;
        st_word   = any_req && !err && req_write && size == SZ_WORD;
        st_sub    = any_req && !err && req_write && size != SZ_WORD;
        mem_read  = ld || st_sub;
        mem_write = st_word || rmw;
        stall     = st_sub;
        mem_addr  = rmw ? 32'(idx_q) : 32'(addr[ADDR_BITS+1:2]);
        mem_wdata = rmw ? merge_q : st_word ? wdata : '0;
        rdata     = ld ? ext : '0;
        state_d   = st_sub ? ST_RMW_WR : ST_IDLE;
        merge_d   = st_sub ? merged : merge_q;
        idx_d     = st_sub ? addr[ADDR_BITS+1:2] : idx_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            merge_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            idx_q   <= idx_d;
        end
    end
endmodule
